composite_video_gen: RTL and testbench



---
 rtl/composite_video_gen.sv | 99 +++++++++
 tb/tb_composite_video_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/composite_video_gen.sv
// composite_video_gen: monochrome composite-video timing and 4-bit DAC level generator
module composite_video_gen #(
    parameter int H_TOTAL     = 1024,
    parameter int H_SYNC      = 75,
    parameter int H_ACT_START = 150,
    parameter int H_ACTIVE    = 832,
    parameter int V_TOTAL     = 262,
    parameter int V_SYNC      = 3,
    parameter int V_ACT_START = 20,
    parameter int V_ACTIVE    = 240,
    parameter int LEVEL_SYNC  = 0,
    parameter int LEVEL_BLACK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] luma,
    output logic       pixel_req,
    output logic [9:0] pixel_x,
    output logic [8:0] pixel_y,
    output logic [3:0] vdac_out,
    output logic       line_start,
    output logic       frame_start
);
    localparam logic [10:0] HT1  = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS   = 11'(H_SYNC);
    localparam logic [10:0] HSER = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] HA0  = 11'(H_ACT_START);
    localparam logic [10:0] HA1  = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0]  VT1  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS   = 10'(V_SYNC);
    localparam logic [9:0]  VA0  = 10'(V_ACT_START);
    localparam logic [9:0]  VA1  = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [3:0]  LS   = 4'(LEVEL_SYNC);
    localparam logic [3:0]  LB   = 4'(LEVEL_BLACK);

    logic [9:0]  h;
    logic [8:0]  v;
    logic [10:0] hx;
    logic [10:0] h2;
    logic [9:0]  vx;
    logic        v_act;
    logic        h_act;
    logic        h2_act;
    logic [3:0]  level;

    assign hx     = {1'b0, h};
    assign h2     = hx + 11'd2;
    assign vx     = {1'b0, v};
    assign v_act  = vx >= VA0 && vx < VA1;
    assign h_act  = hx >= HA0 && hx < HA1;
    assign h2_act = h2 >= HA0 && h2 < HA1;

    // Region priority: vsync line (with serration), hsync, active pixel, black
    always_comb begin
        level = vx < VS ? (hx < HSER ? LS : LB) :
                hx < HS ? LS :
                (h_act && v_act) ? LB + {2'b00, luma} * 4'd3 : LB;
    end

    // Line/frame counters; h wraps every line, v advances on the h wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= hx == HT1 ? '0 : h + 10'd1;
            if (hx == HT1) v <= vx == VT1 ? '0 : v + 9'd1;
        end
    end

    // Request is issued one counter step early so luma arrives in time for its pixel;
    // the active window never reaches the line end, so h+2 never crosses a line wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_req <= 1'b0;
            pixel_x   <= '0;
            pixel_y   <= '0;
        end else begin
            pixel_req <= h2_act && v_act;
            if (h2_act && v_act) begin
                pixel_x <= 10'(h2 - HA0);
                pixel_y <= 9'(vx - VA0);
            end
        end
    end

    // DAC level and line/frame markers registered together for the current counter
    always_ff @(posedge clk) begin
        if (reset) begin
            vdac_out    <= LB;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vdac_out    <= level;
            line_start  <= h == '0;
            frame_start <= h == '0 && v == '0;
        end
    end
endmodule

// File: tb/tb_composite_video_gen.sv
// tb_composite_video_gen: scoreboard bench with a cycle-level reference model of the video timing
module tb_composite_video_gen;
    localparam int HT = 1024, HS = 75, HA = 150, HN = 832;
    localparam int VT = 26, VS = 3, VA = 10, VN = 12;
    localparam int LSY = 0, LBK = 4;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic [3:0] vdac;
        logic       ls;
        logic       fs;
        logic       req;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] luma = 2'd0;
    logic       pixel_req;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic [3:0] vdac_out;
    logic       line_start;
    logic       frame_start;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int mh = 0, mv = 0, mx = 0, my = 0;
    int cyc_n = 0;
    int fs_t[$];
    int ls_t[$];
    int req_f0 = 0;

    composite_video_gen #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA), .H_ACTIVE(HN),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA), .V_ACTIVE(VN),
        .LEVEL_SYNC(LSY), .LEVEL_BLACK(LBK)
    ) dut (
        .clk(clk), .reset(reset), .luma(luma),
        .pixel_req(pixel_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .vdac_out(vdac_out), .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            if (n_bad <= 25) $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc_n, act, want);
        end
    endtask

    function automatic int ref_level(input int h, input int v, input int l);
        if (v < VS) return h < HT - HS ? LSY : LBK;
        if (h < HS) return LSY;
        if (h >= HA && h < HA + HN && v >= VA && v < VA + VN) return LBK + 3 * l;
        return LBK;
    endfunction

    // One clock of stimulus: drive inputs, predict the registered outputs after the next edge
    task automatic step(input bit r);
        exp_t e;
        int nh, nv;
        bit rq;
        @(negedge clk);
        reset = r;
        luma = 2'($urandom_range(0, 3));
        if (r) begin
            mh = 0; mv = 0; mx = 0; my = 0;
            e = '{vdac: 4'(LBK), ls: 1'b0, fs: 1'b0, req: 1'b0, x: '0, y: '0};
        end else begin
            nh = (mh + 1) % HT;
            nv = (mh == HT - 1) ? (mv + 1) % VT : mv;
            rq = (nh + 1 >= HA) && (nh + 1 < HA + HN) && (nv >= VA) && (nv < VA + VN);
            if (rq) begin
                mx = nh + 1 - HA;
                my = nv - VA;
            end
            e = '{vdac: 4'(ref_level(mh, mv, int'(luma))), ls: mh == 0, fs: mh == 0 && mv == 0,
                  req: rq, x: 10'(mx), y: 9'(my)};
            mh = nh; mv = nv;
        end
        q.push_back(e);
    endtask

    // Monitor: pop one prediction per edge and compare against what the DUT presents
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc_n++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("vdac_out", int'(vdac_out), int'(e.vdac));
            chk("line_start", int'(line_start), int'(e.ls));
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("pixel_req", int'(pixel_req), int'(e.req));
            chk("pixel_x", int'(pixel_x), int'(e.x));
            chk("pixel_y", int'(pixel_y), int'(e.y));
            if (frame_start) fs_t.push_back(cyc_n);
            if (line_start && ls_t.size() < 4) ls_t.push_back(cyc_n);
            if (pixel_req && fs_t.size() == 1) req_f0++;
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 2 * FR + 12 * HT + 500; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 5 * HT; i++) step(1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        chk("frame_start_count", fs_t.size(), 4);
        if (fs_t.size() >= 3) begin
            chk("frame_period_0", fs_t[1] - fs_t[0], FR);
            chk("frame_period_1", fs_t[2] - fs_t[1], FR);
        end
        if (ls_t.size() >= 3) begin
            chk("line_period_0", ls_t[1] - ls_t[0], HT);
            chk("line_period_1", ls_t[2] - ls_t[1], HT);
        end
        chk("requests_per_frame", req_f0, VN * HN);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
